// File: rtl/data_mem_access.sv
// MEM-stage load/store unit: one req/ack data-bus transaction per access,
// with misalignment rejection, ack timeout and load extension.
module data_mem_access #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_size,
  input  logic              i_load_unsigned,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic [31:0]       o_mem_data,
  output logic              o_done,
  output logic              o_misalign,
  output logic              o_timeout_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_be,
  output logic [31:0]       o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_size;
  logic [1:0]        r_lane;
  logic              r_uns;
  logic              r_we;
  logic [ADDR_W-1:0] r_baddr;
  logic [3:0]        r_be;
  logic [31:0]       r_bwd;
  logic              r_bus_req;
  logic              r_done;
  logic              r_mis;
  logic              r_to;
  logic [31:0]       r_mem_data;

  logic        w_req;
  logic        w_mis;
  logic [3:0]  w_sbe;
  logic [31:0] w_swd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;

  assign w_req = i_mem_read | i_mem_write;
  // Reserved size 11 is handled exactly like a word.
  assign w_mis = ((i_size == 2'b01) & i_addr[0]) |
                 (i_size[1] & (|i_addr[1:0]));

  always_comb begin
    w_sbe = 4'hF;
    w_swd = i_wdata;
    case (i_size)
      2'b00: begin
        w_sbe = 4'b0001 << i_addr[1:0];
        w_swd = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_sbe = i_addr[1] ? 4'b1100 : 4'b0011;
        w_swd = {2{i_wdata[15:0]}};
      end
      default: begin
        w_sbe = 4'hF;
        w_swd = i_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = i_bus_rdata[7:0];
    case (r_lane)
      2'd0:    w_byte = i_bus_rdata[7:0];
      2'd1:    w_byte = i_bus_rdata[15:8];
      2'd2:    w_byte = i_bus_rdata[23:16];
      default: w_byte = i_bus_rdata[31:24];
    endcase
    w_half = r_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    w_ld   = i_bus_rdata;
    case (r_size)
      2'b00:   w_ld = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ld = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_ld = i_bus_rdata;
    endcase
  end

  always_comb begin
    o_stall = 1'b0;
    case (r_state)
      S_IDLE:  o_stall = w_req;
      S_BUSY:  o_stall = 1'b1;
      default: o_stall = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_size     <= '0;
      r_lane     <= '0;
      r_uns      <= 1'b0;
      r_we       <= 1'b0;
      r_baddr    <= '0;
      r_be       <= '0;
      r_bwd      <= '0;
      r_bus_req  <= 1'b0;
      r_done     <= 1'b0;
      r_mis      <= 1'b0;
      r_to       <= 1'b0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_mis  <= 1'b0;
          r_to   <= 1'b0;
          r_cnt  <= '0;
          if (w_req) begin
            if (w_mis) begin
              r_mis   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_bus_req <= 1'b1;
              r_we      <= i_mem_write;
              r_baddr   <= i_addr[ADDR_W+1:2];
              r_be      <= i_mem_write ? w_sbe : 4'hF;
              r_bwd     <= i_mem_write ? w_swd : 32'h0;
              r_size    <= i_size;
              r_lane    <= i_addr[1:0];
              r_uns     <= i_load_unsigned;
              r_state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (i_bus_ack || r_cnt == CW'(TIMEOUT - 1)) begin
            if (!r_we) r_mem_data <= i_bus_ack ? w_ld : 32'h0;
            r_to      <= ~i_bus_ack;
            r_bus_req <= 1'b0;
            r_we      <= 1'b0;
            r_baddr   <= '0;
            r_be      <= '0;
            r_bwd     <= '0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_mis   <= 1'b0;
          r_to    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_data    = r_mem_data;
  assign o_done        = r_done;
  assign o_misalign    = r_mis;
  assign o_timeout_err = r_to;
  assign o_bus_req     = r_bus_req;
  assign o_bus_we      = r_we;
  assign o_bus_addr    = r_baddr;
  assign o_bus_be      = r_be;
  assign o_bus_wdata   = r_bwd;

endmodule
